// File: rtl/data_mem_bridge.sv
//------------------------------------------------------------------------------
// data_mem_bridge
//
// Turns each 32-bit word load/store from the core's data-memory port into four
// sequential byte transfers on a byte-wide valid/ready memory bus. The core is
// held in stall until the whole word has been moved, then sees a one-cycle
// core_done pulse. Byte lane 0 is the most-significant byte (data[31:24]), so a
// word at address A is {mem[A], mem[A+1], mem[A+2], mem[A+3]}.
//
// Optional feature (compile-time macro MISALIGN_CHECK_EN):
//   defined   - a request whose core_addr[1:0] != 0 is rejected in the same
//               cycle with core_err=1 and core_done=1; no bus activity.
//   undefined - core_err is tied 0 and the low two address bits are ignored.
//
// Ports
//   clk, rst_b       clock (rising edge), asynchronous active-low reset
//   core_req         core requests a word access (held while core_stall=1)
//   core_we          1 = store, 0 = load, sampled with core_req
//   core_addr        byte address of the word
//   core_wdata       store data, lane 0 = [31:24]
//   core_rdata       load data, valid with core_done, held until next load
//   core_stall       core must freeze while this is high
//   core_done        one-cycle pulse at the end of a word access
//   core_err         misalignment pulse (feature build only)
//   ext_valid        byte transfer request
//   ext_ready        memory accepts; transfer happens on valid & ready
//   ext_we           byte write strobe, qualified by ext_valid
//   ext_addr         byte address
//   ext_wdata        byte write data
//   ext_rdata        byte read data, valid in the handshake cycle
//------------------------------------------------------------------------------
module data_mem_bridge #(
   parameter int ADDR_W = 32,
   parameter int BYTES  = 4
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [31:0]       core_wdata,
   output logic [31:0]       core_rdata,
   output logic              core_stall,
   output logic              core_done,
   output logic              core_err,
   output logic              ext_valid,
   input  logic              ext_ready,
   output logic              ext_we,
   output logic [ADDR_W-1:0] ext_addr,
   output logic [7:0]        ext_wdata,
   input  logic [7:0]        ext_rdata
);

   // Word is fixed at 32 bits, so the byte counter is 2 bits wide.
   localparam logic [1:0] LAST_CNT = 2'(BYTES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nxt;

   logic [1:0]          cnt;
   logic [ADDR_W-3:0]   word_q;     // word index; low two bits come from cnt
   logic                we_q;
   logic [31:0]         wdata_q;
   logic [31:0]         rbuf;       // load assembly buffer, not visible to core
   logic [31:0]         rbuf_nxt;
   logic [31:0]         rdata_q;    // architecturally visible load result

   logic                misalign;
   logic                accept;
   logic                hs;
   logic                last_hs;
   logic [7:0]          wbyte;

   //---------------------------------------------------------------------------
   // Misalignment detection
   //---------------------------------------------------------------------------
`ifdef MISALIGN_CHECK_EN
   assign misalign = (core_addr[1:0] != 2'b00);
`else
   // Low address bits are deliberately discarded in this build.
   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^core_addr[1:0];
   assign misalign         = 1'b0;
`endif

   // A request is only taken in IDLE; misaligned ones are answered in place.
   assign accept  = (state == IDLE) && core_req && !misalign;
   assign hs      = (state == XFER) && ext_ready;
   assign last_hs = hs && (cnt == LAST_CNT);

   //---------------------------------------------------------------------------
   // FSM: state register
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) state <= IDLE;
      else        state <= state_nxt;
   end

   //---------------------------------------------------------------------------
   // FSM: next-state logic
   //---------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept)  state_nxt = XFER;
         XFER:    if (last_hs) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   //---------------------------------------------------------------------------
   // Byte lane selection (lane 0 = MSB)
   //---------------------------------------------------------------------------
   always_comb begin
      wbyte = 8'h00;
      unique case (cnt)
         2'd0: wbyte = wdata_q[31:24];
         2'd1: wbyte = wdata_q[23:16];
         2'd2: wbyte = wdata_q[15:8];
         2'd3: wbyte = wdata_q[7:0];
         default: wbyte = 8'h00;
      endcase
   end

   // Read buffer with the current lane replaced by the incoming byte. Used for
   // the final lane so the complete word lands in rdata_q in one step.
   always_comb begin
      rbuf_nxt = rbuf;
      unique case (cnt)
         2'd0: rbuf_nxt[31:24] = ext_rdata;
         2'd1: rbuf_nxt[23:16] = ext_rdata;
         2'd2: rbuf_nxt[15:8]  = ext_rdata;
         2'd3: rbuf_nxt[7:0]   = ext_rdata;
         default: rbuf_nxt = rbuf;
      endcase
   end

   //---------------------------------------------------------------------------
   // Datapath registers
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         cnt     <= 2'd0;
         word_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= 32'h0;
         rbuf    <= 32'h0;
         rdata_q <= 32'h0;
      end else begin
         if (accept) begin
            cnt     <= 2'd0;
            word_q  <= core_addr[ADDR_W-1:2];
            we_q    <= core_we;
            wdata_q <= core_wdata;
         end else if (hs) begin
            // Wraps to 0 on the last byte; never carries into word_q.
            cnt <= cnt + 2'd1;
         end

         if (hs && !we_q) begin
            rbuf <= rbuf_nxt;
            // Publish the word only once it is complete, so core_rdata
            // changes exactly as the DONE cycle begins.
            if (last_hs) rdata_q <= rbuf_nxt;
         end
      end
   end

   //---------------------------------------------------------------------------
   // FSM: output logic
   //---------------------------------------------------------------------------
   always_comb begin
      core_stall = 1'b0;
      core_done  = 1'b0;
      core_err   = 1'b0;
      ext_valid  = 1'b0;
      ext_we     = 1'b0;
      ext_addr   = '0;
      ext_wdata  = 8'h00;
      unique case (state)
         IDLE: begin
            // Combinational so the core stalls in its request cycle.
            core_stall = core_req && !misalign;
            core_done  = core_req && misalign;
            core_err   = core_req && misalign;
         end
         XFER: begin
            // All bus fields are register-driven and only change on a
            // handshake, which keeps them stable while ready is low.
            core_stall = 1'b1;
            ext_valid  = 1'b1;
            ext_we     = we_q;
            ext_addr   = {word_q, cnt};
            ext_wdata  = wbyte;
         end
         DONE: begin
            core_done = 1'b1;
         end
         default: ;
      endcase
   end

   assign core_rdata = rdata_q;

endmodule

// File: tb/tb_data_mem_bridge.sv
module tb_data_mem_bridge;

   localparam int ADDR_W = 32;

   logic              clk = 1'b0;
   logic              rst_b = 1'b0;
   logic              core_req = 1'b0;
   logic              core_we = 1'b0;
   logic [ADDR_W-1:0] core_addr = '0;
   logic [31:0]       core_wdata = 32'h0;
   logic [31:0]       core_rdata;
   logic              core_stall;
   logic              core_done;
   logic              core_err;
   logic              ext_valid;
   logic              ext_ready = 1'b0;
   logic              ext_we;
   logic [ADDR_W-1:0] ext_addr;
   logic [7:0]        ext_wdata;
   logic [7:0]        ext_rdata;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   data_mem_bridge #(.ADDR_W(ADDR_W), .BYTES(4)) dut (
      .clk        (clk),
      .rst_b      (rst_b),
      .core_req   (core_req),
      .core_we    (core_we),
      .core_addr  (core_addr),
      .core_wdata (core_wdata),
      .core_rdata (core_rdata),
      .core_stall (core_stall),
      .core_done  (core_done),
      .core_err   (core_err),
      .ext_valid  (ext_valid),
      .ext_ready  (ext_ready),
      .ext_we     (ext_we),
      .ext_addr   (ext_addr),
      .ext_wdata  (ext_wdata),
      .ext_rdata  (ext_rdata)
   );

   // Byte memory: 1 KiB, preloaded on the first clock edge.
   logic [7:0] mem [0:1023];
   logic       mem_init_done = 1'b0;

   assign ext_rdata = mem[ext_addr[9:0]];

   always @(posedge clk) begin
      if (!mem_init_done) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
         mem[10'h200] <= 8'h11;
         mem[10'h201] <= 8'h22;
         mem[10'h202] <= 8'h33;
         mem[10'h203] <= 8'h44;
         mem_init_done <= 1'b1;
      end else if (ext_valid && ext_ready && ext_we) begin
         mem[ext_addr[9:0]] <= ext_wdata;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          mode;      // 0: ready held high, 1: ready toggles 1/0 in XFER
      int          gap;       // idle cycles (core_req=0) before the request
      logic [31:0] exp_rdata;
      int          exp_cyc;
      logic        exp_err;
   } vec_t;

   vec_t tv [9];

   // One word access. Inputs driven at negedge, outputs sampled 1 time unit later.
   task automatic run_access(input vec_t v);
      int          hs;
      logic        done_seen;
      logic [31:0] base;
      logic [31:0] exp_byte;
      base = v.addr & 32'hFFFF_FFFC;
      for (int g = 0; g < v.gap; g++) begin
         @(negedge clk);
         core_req  = 1'b0;
         ext_ready = 1'b0;
         #1;
         chk("idle_stall", core_stall, 0);
         chk("idle_valid", ext_valid, 0);
      end
      hs = 0;
      done_seen = 1'b0;
      for (int cyc = 0; cyc < 40 && !done_seen; cyc++) begin
         @(negedge clk);
         core_req   = 1'b1;
         core_we    = v.we;
         core_addr  = v.addr;
         core_wdata = v.wdata;
         ext_ready  = (v.mode == 0) ? 1'b1 : ((cyc % 2) == 1);
         #1;
         if (core_done) begin
            done_seen = 1'b1;
            chk("done_cycle", cyc + 1, v.exp_cyc);
            chk("done_rdata", core_rdata, v.exp_rdata);
            chk("done_err", core_err, v.exp_err);
            chk("done_stall", core_stall, 0);
            chk("done_valid", ext_valid, 0);
            chk("byte_count", hs, v.exp_err ? 0 : 4);
         end else begin
            chk("busy_stall", core_stall, 1);
            if (cyc == 0) chk("req_cycle_valid", ext_valid, 0);
            if (ext_valid) begin
               exp_byte = (v.wdata >> (8 * (3 - hs))) & 32'hFF;
               chk("ext_addr", ext_addr, base + hs);
               chk("ext_we", ext_we, v.we);
               if (v.we) chk("ext_wdata", ext_wdata, exp_byte);
               if (ext_ready) hs++;
            end
         end
      end
      if (!done_seen) begin
         n_chk++;
         n_fail++;
         $display("FAIL access_timeout: no core_done within 40 cycles for addr %h", v.addr);
      end
   endtask

   initial begin
      //        we    addr          wdata         mode gap exp_rdata     cyc err
      tv[0] = '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 0, 2, 32'h0000_0000, 6, 1'b0};
      tv[1] = '{1'b0, 32'h0000_0200, 32'h0000_0000, 1, 1, 32'h1122_3344, 9, 1'b0};
      tv[2] = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 0, 1, 32'h1122_3344, 6, 1'b0};
      tv[3] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 0, 0, 32'hCAFE_F00D, 6, 1'b0};
      tv[4] = '{1'b0, 32'h0000_0100, 32'h0000_0000, 1, 0, 32'hDEAD_BEEF, 9, 1'b0};
`ifdef MISALIGN_CHECK_EN
      tv[5] = '{1'b0, 32'h0000_0203, 32'h0000_0000, 0, 1, 32'hDEAD_BEEF, 1, 1'b1};
      tv[6] = '{1'b1, 32'h0000_01FF, 32'hA1B2_C3D4, 0, 1, 32'hDEAD_BEEF, 1, 1'b1};
      tv[7] = '{1'b0, 32'h0000_01FC, 32'h0000_0000, 0, 0, 32'h0000_0000, 6, 1'b0};
`else
      tv[5] = '{1'b0, 32'h0000_0203, 32'h0000_0000, 0, 1, 32'h1122_3344, 6, 1'b0};
      tv[6] = '{1'b1, 32'h0000_01FF, 32'hA1B2_C3D4, 0, 1, 32'h1122_3344, 6, 1'b0};
      tv[7] = '{1'b0, 32'h0000_01FC, 32'h0000_0000, 0, 0, 32'hA1B2_C3D4, 6, 1'b0};
`endif
      tv[8] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 0, 1, 32'hCAFE_F00D, 6, 1'b0};

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_stall", core_stall, 0);
      chk("rst_done", core_done, 0);
      chk("rst_err", core_err, 0);
      chk("rst_valid", ext_valid, 0);
      chk("rst_addr", ext_addr, 0);
      chk("rst_wdata", ext_wdata, 0);
      chk("rst_rdata", core_rdata, 0);
      @(negedge clk);
      rst_b = 1'b1;

      for (int i = 0; i < 9; i++) run_access(tv[i]);

      // Asynchronous reset after two bytes of a load have been transferred.
      @(negedge clk);
      core_req  = 1'b0;
      ext_ready = 1'b0;
      @(negedge clk);
      core_req  = 1'b1;
      core_we   = 1'b0;
      core_addr = 32'h0000_0200;
      ext_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("pre_rst_valid", ext_valid, 1);
      chk("pre_rst_addr", ext_addr, 32'h0000_0202);
      rst_b    = 1'b0;
      core_req = 1'b0;
      #1;
      chk("mid_rst_valid", ext_valid, 0);
      chk("mid_rst_addr", ext_addr, 0);
      chk("mid_rst_stall", core_stall, 0);
      chk("mid_rst_done", core_done, 0);
      chk("mid_rst_rdata", core_rdata, 0);
      @(negedge clk);
      rst_b = 1'b1;
      run_access('{1'b0, 32'h0000_0100, 32'h0000_0000, 0, 1, 32'hDEAD_BEEF, 6, 1'b0});

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
